// File: rtl/montgomery_multiplier.sv
// Iterative radix-2 Montgomery multiplier: result = A*B*2^-N mod M, one operand bit per cycle.
// A capture in IDLE is followed by N LOOP cycles, one REDUCE cycle and a single-cycle DONE pulse.
module montgomery_multiplier #(
    parameter int N = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [1:0]   state_dbg
);

    // Handshake: start is accepted only when busy is low (IDLE); done marks result valid for one cycle.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOP   = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  m_reg;
    logic [N+1:0]  c_reg;
    logic [CW-1:0] cnt;
    logic [N+1:0]  t_add_b;
    logic [N+1:0]  t_add_m;
    logic          c_ge_m;
    logic [N-1:0]  c_minus_m;
    logic [N-1:0]  reduced;
    logic          last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_bit = (cnt == CW'(N - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LOOP;
            S_LOOP:   if (last_bit) state_next = S_REDUCE;
            S_REDUCE: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // C stays below 2M, so C + B + M < 4M fits in N+2 bits.
    always_comb begin
        t_add_b = c_reg + (a_reg[0] ? {2'b00, b_reg} : '0);
        t_add_m = t_add_b + (t_add_b[0] ? {2'b00, m_reg} : '0);
    end

    // C < 2M means C - M < M, so the low N bits of the difference are exact.
    always_comb begin
        c_ge_m    = (c_reg >= {2'b00, m_reg});
        c_minus_m = c_reg[N-1:0] - m_reg;
        reduced   = c_ge_m ? c_minus_m : c_reg[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            c_reg  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                        c_reg <= '0;
                        cnt   <= '0;
                    end
                end
                S_LOOP: begin
                    a_reg <= a_reg >> 1;
                    c_reg <= t_add_m >> 1;
                    cnt   <= cnt + 1'b1;
                end
                S_REDUCE: begin
                    result <= reduced;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_multiplier.sv
// Bench for montgomery_multiplier: an N=8 instance with hand-computed vectors and an N=512
// instance whose operands are built as k*(R mod M) so the expected product is k*B mod M.
module tb_montgomery_multiplier;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, m8 = '0;
    logic         busy8, done8;
    logic [7:0]   res8;
    logic [1:0]   st8;

    logic         start512 = 1'b0;
    logic [511:0] a512 = '0, b512 = '0, m512 = '0;
    logic         busy512, done512;
    logic [511:0] res512;
    logic [1:0]   st512;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]   exp8_q[$];
    int           cap8_q[$];
    bit           chk8_q[$];
    logic [511:0] exp512_q[$];
    int           cap512_q[$];

    logic [7:0]   last8 = '0;
    bit           known8 = 1'b1;
    logic [511:0] last512 = '0;
    logic [511:0] mod512;

    montgomery_multiplier #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .in_a(a8), .in_b(b8), .in_m(m8),
        .busy(busy8), .done(done8), .result(res8), .state_dbg(st8)
    );

    montgomery_multiplier #(.N(512)) dut512 (
        .clk(clk), .reset(reset), .start(start512),
        .in_a(a512), .in_b(b512), .in_m(m512),
        .busy(busy512), .done(done512), .result(res512), .state_dbg(st512)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor for the N=8 instance.
    always @(negedge clk) begin
        logic [7:0] e;
        int c;
        bit k;
        if (!reset && done8) begin
            if (exp8_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done8_unexpected: done8 high at cycle %0d with no operation pending", cyc);
            end else begin
                e = exp8_q.pop_front();
                c = cap8_q.pop_front();
                k = chk8_q.pop_front();
                if (k) begin
                    checks++;
                    if (res8 !== e) begin
                        errors++;
                        $display("FAIL result8: got %0d expected %0d", res8, e);
                    end
                end
                checks++;
                if (cyc - c != 10) begin
                    errors++;
                    $display("FAIL latency8: got %0d expected 10", cyc - c);
                end
                checks++;
                if (busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy8_at_done: got %b expected 1", busy8);
                end
                last8 = e;
                known8 = k;
            end
        end
    end

    // Monitor for the N=512 instance.
    always @(negedge clk) begin
        logic [511:0] e;
        int c;
        if (!reset && done512) begin
            if (exp512_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done512_unexpected: done512 high at cycle %0d with no operation pending", cyc);
            end else begin
                e = exp512_q.pop_front();
                c = cap512_q.pop_front();
                checks++;
                if (res512 !== e) begin
                    errors++;
                    $display("FAIL result512: got %h expected %h", res512, e);
                end
                checks++;
                if (cyc - c != 514) begin
                    errors++;
                    $display("FAIL latency512: got %0d expected 514", cyc - c);
                end
                last512 = e;
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] e, input bit chk);
        int n;
        n = 0;
        @(negedge clk);
        while (busy8 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL idle8_timeout: busy8 still %b after %0d cycles", busy8, n);
        end
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        exp8_q.push_back(e);
        cap8_q.push_back(cyc);
        chk8_q.push_back(chk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy8_after_start: got %b expected 1", busy8);
        end
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL done8_after_start: got %b expected 0", done8);
        end
        repeat (3) @(negedge clk);
        if (known8) begin
            checks++;
            if (res8 !== last8) begin
                errors++;
                $display("FAIL res8_held_in_loop: got %0d expected %0d", res8, last8);
            end
        end
    endtask

    task automatic op512(input logic [511:0] a, input logic [511:0] b,
                         input logic [511:0] e, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (busy512 !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL idle512_timeout: busy512 still %b after %0d cycles", busy512, n);
        end
        a512 = a; b512 = b; m512 = mod512; start512 = 1'b1;
        exp512_q.push_back(e);
        cap512_q.push_back(cyc);
        @(negedge clk);
        if (!hold) start512 = 1'b0;
        checks++;
        if (busy512 !== 1'b1) begin
            errors++;
            $display("FAIL busy512_after_start: got %b expected 1", busy512);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res512 !== last512) begin
            errors++;
            $display("FAIL res512_held_in_loop: got %h expected %h", res512, last512);
        end
    endtask

    // With A = k*(R mod M), the Montgomery product reduces to k*B mod M.
    function automatic logic [511:0] ref512(input logic [31:0] k, input logic [511:0] b,
                                            input logic [511:0] m);
        logic [1023:0] p;
        p = {992'b0, k} * {512'b0, b};
        p = p % {512'b0, m};
        return p[511:0];
    endfunction

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp8_q.size() != 0 || exp512_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d operations still pending", exp8_q.size(), exp512_q.size());
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic [511:0] b, a;
        logic [31:0]  k;

        // R mod M = 569 for this modulus.
        mod512 = {512{1'b1}} - 512'd568;

        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0 || st8 !== 2'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b result=%0d state=%0d expected 0 0 0 0", busy8, done8, res8, st8);
        end
        checks++;
        if (busy512 !== 1'b0 || done512 !== 1'b0 || res512 !== '0 || st512 !== 2'd0) begin
            errors++;
            $display("FAIL reset512: busy=%b done=%b state=%0d expected 0 0 0 with zero result", busy512, done512, st512);
        end
        reset = 1'b0;

        // N=8 directed vectors; for M=13, R mod M = 9 and R^-1 mod M = 3.
        op8(8'd5,  8'd7,   8'd13,  8'd1,   1'b1);
        op8(8'd12, 8'd12,  8'd13,  8'd3,   1'b1);
        op8(8'd9,  8'd7,   8'd13,  8'd7,   1'b1);
        op8(8'd0,  8'd12,  8'd13,  8'd0,   1'b1);
        op8(8'd7,  8'd0,   8'd13,  8'd0,   1'b1);
        op8(8'd1,  8'd1,   8'd13,  8'd3,   1'b1);
        op8(8'd12, 8'd1,   8'd13,  8'd10,  1'b1);
        op8(8'd2,  8'd3,   8'd13,  8'd5,   1'b1);
        op8(8'd5,  8'd200, 8'd251, 8'd200, 1'b1);
        op8(8'd1,  8'd100, 8'd255, 8'd100, 1'b1);
        op8(8'd3,  8'd5,   8'd12,  8'd0,   1'b0);

        // Start pulsed mid-LOOP with other operands must be ignored.
        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b1);
        a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain(200);

        // Reset in LOOP cycle 4 abandons the operation.
        a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0 || st8 !== 2'd0) begin
            errors++;
            $display("FAIL reset8_midloop: busy=%b done=%b result=%0d state=%0d expected 0 0 0 0", busy8, done8, res8, st8);
        end
        reset = 1'b0;
        last8 = '0;
        known8 = 1'b1;
        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b1);
        drain(200);

        // N=512 with start held high across back-to-back operations.
        op512(512'd323761, 512'd1, 512'd569, 1'b1);
        op512(512'd0, mod512 - 512'd12345, 512'd0, 1'b1);
        op512(512'd569, mod512 - 512'd1, mod512 - 512'd1, 1'b1);
        op512(512'd569 * 512'd77, 512'd0, 512'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 16; w++) b[w*32 +: 32] = $urandom;
            if (b >= mod512) b = b - mod512;
            k = 32'($urandom_range(1, 5000));
            a = {480'b0, k} * 512'd569;
            if (i == 7) op512(a, a, ref512(k, a, mod512), 1'b0);
            else        op512(a, b, ref512(k, b, mod512), 1'b1);
        end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
